// File: rtl/inv_response_checker.sv
// Response checker for inverter DUTs: after each stim_valid pulse waits SETTLE_CYCLES, compares resp against ~stim, counts pass/fail.
// Latency: counter updates visible SETTLE_CYCLES+2 cycles after the stim_valid pulse cycle; verdict in DONE after num_vectors compares.
// Backpressure: none; stim_valid outside ARM during a run is dropped and sets sticky overrun. Optional macro: INV_CHK_FIRST_FAIL_EN.
module inv_response_checker #(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [WIDTH-1:0] stim,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             overrun
`ifdef INV_CHK_FIRST_FAIL_EN
  ,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_stim,
  output logic [WIDTH-1:0] first_fail_resp
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ARM, SETTLE, COMPARE, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] stim_q;
  logic [SW-1:0]    settle_cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W:0]   vec_inc;
  logic             last_vec;
  logic             match;

  // Compare the post-increment vector count at full width so target=max never aliases.
  assign vec_inc  = {1'b0, vec_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last_vec = (vec_inc == {1'b0, target});
  assign match    = (resp == ~stim_q);

  assign busy = (state == ARM) || (state == SETTLE) || (state == COMPARE);
  assign done = (state == DONE);
  assign pass = done && (fail_cnt == '0) && !overrun;

  // State register; reset drops straight to IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = (num_vectors == '0) ? DONE : ARM;
      ARM:        if (stim_valid) next_state = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
      SETTLE:     if (settle_cnt == '0) next_state = COMPARE;
      COMPARE:    next_state = last_vec ? DONE : ARM;
      default:    next_state = IDLE;
    endcase
  end

  // Datapath: stimulus capture, settle countdown, saturating counters and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q          <= '0;
      settle_cnt      <= '0;
      target          <= '0;
      vec_cnt         <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      overrun         <= 1'b0;
`ifdef INV_CHK_FIRST_FAIL_EN
      first_fail_idx  <= '0;
      first_fail_stim <= '0;
      first_fail_resp <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            target          <= num_vectors;
            vec_cnt         <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            overrun         <= 1'b0;
`ifdef INV_CHK_FIRST_FAIL_EN
            first_fail_idx  <= '0;
            first_fail_stim <= '0;
            first_fail_resp <= '0;
`endif
          end
        end
        ARM: begin
          if (stim_valid) begin
            stim_q     <= stim;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
          if (stim_valid)       overrun    <= 1'b1;
        end
        COMPARE: begin
          if (stim_valid) overrun <= 1'b1;
          if (vec_cnt != CNT_MAX) vec_cnt <= vec_cnt + CNT_W'(1);
          if (match) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
`ifdef INV_CHK_FIRST_FAIL_EN
            // fail_cnt is cleared on start and never wraps, so zero marks the first mismatch of the run.
            if (fail_cnt == '0) begin
              first_fail_idx  <= vec_cnt;
              first_fail_stim <= stim_q;
              first_fail_resp <= resp;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_response_checker.sv
// Self-checking bench for inv_response_checker: directed scenarios plus randomized runs.
// Expected outputs come from a transaction-level model (accept edge, compare edge = accept+S+1).
// Outputs are compared every cycle on the falling edge.
module tb_inv_response_checker;
  localparam int W    = 4;
  localparam int S    = 2;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          stim_valid = 1'b0;
  logic [CW-1:0] num_vectors = '0;
  logic [W-1:0]  stim = '0;
  logic [W-1:0]  resp = '0;
  logic          busy, done, pass, overrun;
  logic [CW-1:0] vec_cnt, pass_cnt, fail_cnt;
`ifdef INV_CHK_FIRST_FAIL_EN
  logic [CW-1:0] first_fail_idx;
  logic [W-1:0]  first_fail_stim, first_fail_resp;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inv_response_checker #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .stim(stim), .stim_valid(stim_valid), .resp(resp),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .overrun(overrun)
`ifdef INV_CHK_FIRST_FAIL_EN
    , .first_fail_idx(first_fail_idx), .first_fail_stim(first_fail_stim),
    .first_fail_resp(first_fail_resp)
`endif
  );

  // Reference model state
  logic         m_busy, m_done, m_ov, m_pend;
  int           m_vec, m_pc, m_fc, m_target;
  logic [W-1:0] m_stim;
  longint       k = 0;
  longint       m_cmp_edge;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_ov = 0; m_pend = 0;
    m_vec = 0; m_pc = 0; m_fc = 0; m_target = 0; m_stim = '0; m_cmp_edge = 0;
  endtask

  function automatic logic [31:0] got_outs();
    return 32'({busy, done, pass, overrun, vec_cnt, pass_cnt, fail_cnt});
  endfunction

  function automatic logic [31:0] exp_outs();
    logic mp;
    mp = m_done && (m_fc == 0) && !m_ov;
    return 32'({m_busy, m_done, mp, m_ov, CW'(m_vec), CW'(m_pc), CW'(m_fc)});
  endfunction

  // Apply the rules for one rising edge using the inputs presented to it.
  task automatic model_step();
    k++;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (m_pend) begin
      if (stim_valid) m_ov = 1'b1;
      if (k == m_cmp_edge) begin
        if (resp == ~m_stim) m_pc = sat(m_pc);
        else                 m_fc = sat(m_fc);
        m_vec  = sat(m_vec);
        m_pend = 1'b0;
        if (m_vec == m_target) begin m_busy = 1'b0; m_done = 1'b1; end
      end
    end else if (m_busy) begin
      if (stim_valid) begin
        m_pend = 1'b1; m_stim = stim; m_cmp_edge = k + S + 1;
      end
    end else if (start) begin
      m_vec = 0; m_pc = 0; m_fc = 0; m_ov = 1'b0; m_target = int'(num_vectors);
      if (num_vectors == '0) begin m_done = 1'b1; m_busy = 1'b0; end
      else                   begin m_done = 1'b0; m_busy = 1'b1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("outs", got_outs(), exp_outs());
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start = 1'b1; num_vectors = n;
    cycle();
    start = 1'b0;
  endtask

  // One vector: pulse, S settle cycles with r_settle, then the compare cycle with r_cmp.
  task automatic send_vec(input logic [W-1:0] s, input logic [W-1:0] r_settle,
                          input logic [W-1:0] r_cmp);
    stim = s; stim_valid = 1'b1; resp = r_settle;
    cycle();
    stim_valid = 1'b0;
    repeat (S) cycle();
    resp = r_cmp;
    cycle();
  endtask

  initial begin
    logic [W-1:0] pat [4];
    logic [W-1:0] last_stim;
    int budget;
    pat[0] = 4'h0; pat[1] = 4'h5; pat[2] = 4'hA; pat[3] = 4'hF;
    m_reset();

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset", got_outs(), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Good run
    do_start(3'd4);
    for (int i = 0; i < 4; i++) send_vec(pat[i], ~pat[i], ~pat[i]);
    check_eq("good_done", 32'(done), 32'd1);
    check_eq("good_pass", 32'(pass), 32'd1);
    check_eq("good_pcnt", 32'(pass_cnt), 32'd4);
    check_eq("good_fcnt", 32'(fail_cnt), 32'd0);
    check_eq("good_vcnt", 32'(vec_cnt), 32'd4);
    cycle();

    // Single fault on the third vector
    do_start(3'd4);
    for (int i = 0; i < 4; i++) send_vec(pat[i], ~pat[i], (i == 2) ? 4'hB : ~pat[i]);
    check_eq("fault_fcnt", 32'(fail_cnt), 32'd1);
    check_eq("fault_pcnt", 32'(pass_cnt), 32'd3);
    check_eq("fault_pass", 32'(pass), 32'd0);
`ifdef INV_CHK_FIRST_FAIL_EN
    check_eq("ff_idx", 32'(first_fail_idx), 32'd2);
    check_eq("ff_stim", 32'(first_fail_stim), 32'hA);
    check_eq("ff_resp", 32'(first_fail_resp), 32'hB);
`endif

    // Settle window: only the compare-cycle sample counts
    do_start(3'd2);
    send_vec(4'h3, 4'h3, 4'hC);
    check_eq("settle_ok", 32'(pass_cnt), 32'd1);
    send_vec(4'h6, 4'h9, 4'h6);
    check_eq("settle_bad", 32'(fail_cnt), 32'd1);

    // Zero vectors
    do_start(3'd0);
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_pass", 32'(pass), 32'd1);
    check_eq("zero_vcnt", 32'(vec_cnt), 32'd0);

    // Overrun: second pulse lands in SETTLE
    do_start(3'd2);
    stim = 4'h1; resp = 4'hE; stim_valid = 1'b1;
    cycle();
    stim = 4'h2;
    cycle();
    stim_valid = 1'b0;
    repeat (S) cycle();
    check_eq("ovr_vcnt1", 32'(vec_cnt), 32'd1);
    check_eq("ovr_busy", 32'(busy), 32'd1);
    send_vec(4'h2, 4'hD, 4'hD);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_vcnt2", 32'(vec_cnt), 32'd2);
    check_eq("ovr_pass", 32'(pass), 32'd0);

    // Reset in the middle of vector 2's settle window
    do_start(3'd3);
    send_vec(4'h7, 4'h8, 4'h8);
    stim = 4'h4; stim_valid = 1'b1;
    cycle();
    stim_valid = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    check_eq("arst", got_outs(), 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();
    do_start(3'd2);
    check_eq("arst_vcnt0", 32'(vec_cnt), 32'd0);
    send_vec(4'h9, 4'h6, 4'h6);
    send_vec(4'h1, 4'hE, 4'hE);
    check_eq("arst_rerun", 32'(pass), 32'd1);

    // Saturation at 7 vectors with an ignored start mid-run
    do_start(3'd7);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        start = 1'b1; num_vectors = 3'd1;
        cycle();
        start = 1'b0;
        check_eq("busy_start", 32'(vec_cnt), 32'd3);
      end
      send_vec(W'(i), ~W'(i), ~W'(i));
    end
    check_eq("sat_pcnt", 32'(pass_cnt), 32'd7);
    check_eq("sat_vcnt", 32'(vec_cnt), 32'd7);
    check_eq("sat_done", 32'(done), 32'd1);
    do_start(3'd3);
    check_eq("restart_pcnt", 32'(pass_cnt), 32'd0);
    check_eq("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) send_vec(W'(i + 8), ~W'(i + 8), ~W'(i + 8));

    // Randomized runs
    last_stim = '0;
    for (int run = 0; run < 25; run++) begin
      do_start(CW'($urandom_range(0, CMAX)));
      budget = 0;
      while (!m_done && budget < 300) begin
        stim_valid = ($urandom % 3 == 0);
        stim = W'($urandom);
        if (stim_valid) last_stim = stim;
        resp = ($urandom % 6 == 0) ? W'($urandom) : ~last_stim;
        start = m_busy && ($urandom % 40 == 0);
        num_vectors = CW'($urandom);
        cycle();
        budget++;
      end
      stim_valid = 1'b0; start = 1'b0;
      check_eq("rand_done", 32'(done), 32'd1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
